cbu_interval_timer_ctrl: RTL and testbench

//  Programmable interval-timer controller built around a WIDTH-bit cascaded up-counter
//  (chain of 8-bit carry-in/carry-out up-counter stages).

---
 rtl/cbu_interval_timer_ctrl_if.sv | 25 ++
 rtl/cbu_interval_timer_ctrl.sv | 145 ++++++++++++++
 tb/tb_cbu_interval_timer_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cbu_interval_timer_ctrl_if.sv
// Host-to-timer bundle: commands and shadowed parameters in, counter state and status out.
interface cbu_interval_timer_ctrl_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 4
);
  logic                  START;
  logic                  STOP;
  logic                  MODE;
  logic [WIDTH-1:0]      LOAD_VAL;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic [WIDTH-1:0]      COUNT;
  logic                  TC;
  logic                  BUSY;
  logic                  DONE;

  modport master (
    output START, STOP, MODE, LOAD_VAL, PRESCALE,
    input  COUNT, TC, BUSY, DONE
  );

  modport slave (
    input  START, STOP, MODE, LOAD_VAL, PRESCALE,
    output COUNT, TC, BUSY, DONE
  );
endinterface

// File: rtl/cbu_interval_timer_ctrl.sv
// Interval-timer controller: sequences a cascaded 8-bit up-counter chain through
// load/run/terminal phases with a prescaled count enable, one-shot or periodic.
module cbu_interval_timer_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 4
) (
  input logic                     CLK,
  input logic                     CD,
  cbu_interval_timer_ctrl_if.slave tif
);

  localparam int unsigned NStages = WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StFin} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      load_val_q, load_val_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
  logic                  mode_q, mode_d;
  logic                  tc_q, tc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  tick;
  logic                  carry;
  logic [WIDTH-1:0]      count_inc;
  logic [NStages:0]      stage_ci;

  assign tick        = (prescaler_q == prescale_q);
  assign stage_ci[0] = tick;

  // Counter chain: each byte stage adds its carry-in and ripples its carry-out onward.
  for (genvar i = 0; i < NStages; i++) begin : g_stage
    assign {stage_ci[i+1], count_inc[i*8 +: 8]} =
        {1'b0, count_q[i*8 +: 8]} + {8'd0, stage_ci[i]};
  end

  assign carry = stage_ci[NStages];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    load_val_d  = load_val_q;
    prescale_d  = prescale_q;
    prescaler_d = prescaler_q;
    mode_d      = mode_q;
    tc_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;

    unique case (state_q)
      StIdle: begin
        if (tif.START && !tif.STOP) begin
          state_d    = StLoad;
          mode_d     = tif.MODE;
          load_val_d = tif.LOAD_VAL;
          prescale_d = tif.PRESCALE;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end

      StLoad, StRun: begin
        if (tif.STOP) begin
          // Abort: counter holds, any tick or carry this cycle is dropped.
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (tif.START) begin
          state_d    = StLoad;
          mode_d     = tif.MODE;
          load_val_d = tif.LOAD_VAL;
          prescale_d = tif.PRESCALE;
        end else if (state_q == StLoad) begin
          state_d     = StRun;
          count_d     = load_val_q;
          prescaler_d = '0;
        end else if (tick) begin
          prescaler_d = '0;
          if (carry) begin
            tc_d = 1'b1;
            if (mode_q) begin
              count_d = load_val_q;
            end else begin
              state_d = StFin;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            count_d = count_inc;
          end
        end else begin
          prescaler_d = prescaler_q + 1'b1;
        end
      end

      StFin: begin
        if (tif.STOP) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end else if (tif.START) begin
          state_d    = StLoad;
          mode_d     = tif.MODE;
          load_val_d = tif.LOAD_VAL;
          prescale_d = tif.PRESCALE;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      state_q     <= StIdle;
      count_q     <= '0;
      load_val_q  <= '0;
      prescale_q  <= '0;
      prescaler_q <= '0;
      mode_q      <= 1'b0;
      tc_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      load_val_q  <= load_val_d;
      prescale_q  <= prescale_d;
      prescaler_q <= prescaler_d;
      mode_q      <= mode_d;
      tc_q        <= tc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tif.COUNT = count_q;
  assign tif.TC    = tc_q;
  assign tif.BUSY  = busy_q;
  assign tif.DONE  = done_q;

endmodule

// File: tb/tb_cbu_interval_timer_ctrl.sv
// Bench for cbu_interval_timer_ctrl: per-cycle vector table plus multi-cycle sequences,
// expected outputs queued at drive time and compared after each rising edge.
module tb_cbu_interval_timer_ctrl;

  logic CLK = 1'b0;
  logic CD  = 1'b1;

  always #5 CLK = ~CLK;

  cbu_interval_timer_ctrl_if #(.WIDTH(16), .PRESCALE_W(4)) tif ();

  cbu_interval_timer_ctrl #(.WIDTH(16), .PRESCALE_W(4)) dut (
    .CLK (CLK),
    .CD  (CD),
    .tif (tif)
  );

  typedef struct {
    logic        start;
    logic        stop;
    logic        mode;
    logic [15:0] lv;
    logic [3:0]  ps;
    logic [15:0] count;
    logic        tc;
    logic        busy;
    logic        done;
  } vec_t;

  typedef struct {
    logic [15:0] count;
    logic        tc;
    logic        busy;
    logic        done;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic start, logic stop, logic mode, logic [15:0] lv,
                              logic [3:0] ps, logic [15:0] count, logic tc, logic busy,
                              logic done);
    vec_t v;
    v.start = start; v.stop = stop; v.mode = mode; v.lv = lv; v.ps = ps;
    v.count = count; v.tc = tc; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic check_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (tif.COUNT !== e.count || tif.TC !== e.tc || tif.BUSY !== e.busy
        || tif.DONE !== e.done) begin
      errors++;
      $display("FAIL %s: got count=%h tc=%b busy=%b done=%b, expected count=%h tc=%b busy=%b done=%b",
               e.name, tif.COUNT, tif.TC, tif.BUSY, tif.DONE, e.count, e.tc, e.busy, e.done);
    end
  endtask

  // One clock: drive at the falling edge, queue the expectation, compare after the rising edge.
  task automatic step(input logic start, input logic stop, input logic mode,
                      input logic [15:0] lv, input logic [3:0] ps, input logic [15:0] count,
                      input logic tc, input logic busy, input logic done, input string name);
    exp_t e;
    @(negedge CLK);
    tif.START    = start;
    tif.STOP     = stop;
    tif.MODE     = mode;
    tif.LOAD_VAL = lv;
    tif.PRESCALE = ps;
    e.count = count; e.tc = tc; e.busy = busy; e.done = done; e.name = name;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    check_pop();
  endtask

  task automatic expect_now(input logic [15:0] count, input logic tc, input logic busy,
                            input logic done, input string name);
    exp_t e;
    e.count = count; e.tc = tc; e.busy = busy; e.done = done; e.name = name;
    sb_q.push_back(e);
    check_pop();
  endtask

  initial begin
    tif.START    = 1'b0;
    tif.STOP     = 1'b0;
    tif.MODE     = 1'b0;
    tif.LOAD_VAL = 16'h0000;
    tif.PRESCALE = 4'd0;

    // One-shot FFFD, prescale 0, then a hold in FIN with ignored input changes.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'hFFFD, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'hFFFD, 4'd0, 16'hFFFD, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'hFFFD, 4'd0, 16'hFFFE, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'hFFFD, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'hFFFD, 4'd0, 16'hFFFF, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'hFFFD, 4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h1234, 4'd7, 16'hFFFF, 1'b0, 1'b0, 1'b1));
    // Restart from FIN with prescale 1, then STOP on the carry cycle.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'hFFFE, 4'd1, 16'hFFFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFE, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFE, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0));
    // Periodic FFFF, prescale 0: TC every cycle, then START+STOP together.
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 16'hFFFF, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0));
    // One-shot FFFF, then STOP in FIN clears DONE; START+STOP in IDLE does nothing.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'hFFFF, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0001, 4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0));

    #3;
    expect_now(16'h0000, 1'b0, 1'b0, 1'b0, "reset_state");
    @(negedge CLK);
    CD = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].lv, vecs[i].ps,
           vecs[i].count, vecs[i].tc, vecs[i].busy, vecs[i].done, $sformatf("vec%0d", i));
    end

    // Periodic FFF0 / prescale 3: each value lasts 4 cycles, TC every 64 cycles.
    step(1'b1, 1'b0, 1'b1, 16'hFFF0, 4'd3, 16'hFFFF, 1'b0, 1'b1, 1'b0, "per_load");
    for (int n = 1; n <= 130; n++) begin
      int m;
      m = n - 1;
      step(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'hFFF0 + 16'((m / 4) % 16),
           (m > 0 && (m % 64) == 0), 1'b1, 1'b0, $sformatf("per_cyc%0d", n));
    end
    step(1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 16'hFFF0, 1'b0, 1'b0, 1'b0, "per_stop");

    // Run up to 1234 and clear asynchronously between edges.
    step(1'b1, 1'b0, 1'b1, 16'h1230, 4'd0, 16'hFFF0, 1'b0, 1'b1, 1'b0, "cd_load");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h1230, 1'b0, 1'b1, 1'b0, "cd_run0");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h1231, 1'b0, 1'b1, 1'b0, "cd_run1");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h1232, 1'b0, 1'b1, 1'b0, "cd_run2");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h1233, 1'b0, 1'b1, 1'b0, "cd_run3");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h1234, 1'b0, 1'b1, 1'b0, "cd_run4");
    #1;
    CD = 1'b1;
    #1;
    expect_now(16'h0000, 1'b0, 1'b0, 1'b0, "cd_async_clear");
    #1;
    CD = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b0, 1'b1, 16'h5555, 4'd2, 16'h0000, 1'b0, 1'b0, 1'b0,
           $sformatf("cd_idle%0d", n));
    end

    // Run from 0000 with prescale 2, then restart as one-shot FFFE with prescale 0.
    step(1'b1, 1'b0, 1'b1, 16'h0000, 4'd2, 16'h0000, 1'b0, 1'b1, 1'b0, "rs_load0");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, "rs_run0");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, "rs_run1");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, "rs_run2");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h0001, 1'b0, 1'b1, 1'b0, "rs_run3");
    step(1'b1, 1'b0, 1'b0, 16'hFFFE, 4'd0, 16'h0001, 1'b0, 1'b1, 1'b0, "rs_load1");
    step(1'b0, 1'b0, 1'b1, 16'h0000, 4'd5, 16'hFFFE, 1'b0, 1'b1, 1'b0, "rs_edge1");
    step(1'b0, 1'b0, 1'b1, 16'h0000, 4'd5, 16'hFFFF, 1'b0, 1'b1, 1'b0, "rs_edge2");
    step(1'b0, 1'b0, 1'b1, 16'h0000, 4'd5, 16'hFFFF, 1'b1, 1'b0, 1'b1, "rs_edge3_tc");
    step(1'b0, 1'b0, 1'b1, 16'h0000, 4'd5, 16'hFFFF, 1'b0, 1'b0, 1'b1, "rs_fin");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
